// File: rtl/pc_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module      : pc_sequencer_pkg
// Description : Shared types, defaults and helpers for the fetch-stage PC
//               sequencer (next-PC select encoding, alignment mask).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

   localparam int unsigned     DEF_XLEN         = 64;
   localparam int unsigned     DEF_INST_BYTES   = 4;
   localparam int unsigned     DEF_RAS_DEPTH    = 4;
   localparam logic [63:0]     DEF_RESET_VECTOR = 64'h0;

   // Source of the PC loaded on the next rising edge, lowest priority first
   typedef enum logic [2:0] {
      SEL_HOLD  = 3'd0,
      SEL_SEQ   = 3'd1,
      SEL_RAS   = 3'd2,
      SEL_REDIR = 3'd3,
      SEL_TRAP  = 3'd4
   } next_pc_sel_e;

   // Mask that clears the address bits below the instruction granule
   function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
      align_mask = ~(64'(inst_bytes) - 64'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : pc_sequencer_if
// Description : Fetch-side bundle between the pipeline (master: EX, trap logic,
//               hazard unit, IMEM) and the PC sequencer (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN
);
   logic            stall;
   logic            fetch_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vector;
   logic            ras_push;
   logic [XLEN-1:0] ras_push_addr;
   logic            ras_pop;
   logic [XLEN-1:0] pc_out;
   logic            pc_valid;
   logic [XLEN-1:0] pc_plus;
   logic            flush;
   logic            misaligned;
   logic            ras_empty;

   modport master (
      output stall, fetch_ready, redirect_valid, redirect_target,
             trap_valid, trap_vector, ras_push, ras_push_addr, ras_pop,
      input  pc_out, pc_valid, pc_plus, flush, misaligned, ras_empty
   );

   modport slave (
      input  stall, fetch_ready, redirect_valid, redirect_target,
             trap_valid, trap_vector, ras_push, ras_push_addr, ras_pop,
      output pc_out, pc_valid, pc_plus, flush, misaligned, ras_empty
   );

endinterface

`default_nettype wire

// File: rtl/pc_sequencer_return_addr_stack.sv
//------------------------------------------------------------------------------
// Module      : return_addr_stack
// Description : Circular return-address stack with saturating occupancy.
//               A push when full overwrites the oldest entry; push+pop in the
//               same cycle replaces the top in place; clear wins over push.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module return_addr_stack
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned XLEN      = DEF_XLEN,
   parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic            push,
   input  wire logic [XLEN-1:0] push_addr,
   input  wire logic            pop,
   input  wire logic            clear,
   output logic      [XLEN-1:0] top,
   output logic                 empty
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  r_entries [RAS_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;     // next free slot; top lives one below
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_top_ptr;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   // Occupancy flags and top-of-stack read
   always_comb begin
      w_top_ptr = r_wr_ptr - PTR_W'(1);
      empty     = (r_count == '0);
      w_full    = (r_count == CNT_W'(RAS_DEPTH));
      w_pop     = pop & ~empty;
      w_push    = push & ~clear;
      top       = r_entries[w_top_ptr];
   end

   // Entry storage: a combined push+pop rewrites the current top in place
   always_ff @(posedge clk) begin
      if (w_push) begin
         if (w_pop) begin
            r_entries[w_top_ptr] <= push_addr;
         end else begin
            r_entries[r_wr_ptr] <= push_addr;
         end
      end
   end

   // Write pointer and saturating count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_push && w_pop) begin
         r_wr_ptr <= r_wr_ptr;
         r_count  <= r_count;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (!w_full) begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (w_pop) begin
         r_wr_ptr <= w_top_ptr;
         r_count  <= r_count - CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module      : pc_sequencer
// Description : Fetch-stage program counter. Picks the next PC from trap,
//               redirect, RAS prediction or sequential increment, aligns loaded
//               targets and flags misalignment and pipeline flushes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR[XLEN-1:0],
   parameter int unsigned     INST_BYTES   = DEF_INST_BYTES,
   parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
   input  wire logic     clk,
   input  wire logic     reset,
   pc_sequencer_if.slave bus
);

   localparam logic [63:0]     ALIGN_MASK_FULL = align_mask(INST_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK      = ALIGN_MASK_FULL[XLEN-1:0];

   logic [XLEN-1:0] r_pc;
   logic            r_pc_valid;
   logic            r_flush;
   logic            r_misaligned;

   next_pc_sel_e    w_sel;
   logic            w_accept;
   logic [XLEN-1:0] w_target;
   logic            w_target_misaligned;
   logic [XLEN-1:0] w_next_pc;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_ras_pop;

   // Next-PC source selection in strict priority order
   always_comb begin
      w_accept = r_pc_valid & bus.fetch_ready & ~bus.stall;
      w_sel    = SEL_HOLD;
      if (bus.trap_valid) begin
         w_sel = SEL_TRAP;
      end else if (bus.redirect_valid) begin
         w_sel = SEL_REDIR;
      end else if (w_accept && bus.ras_pop && !w_ras_empty) begin
         w_sel = SEL_RAS;
      end else if (w_accept) begin
         w_sel = SEL_SEQ;
      end
      // RAS only pops when its prediction is actually taken
      w_ras_pop = (w_sel == SEL_RAS);
   end

   // Next-PC value; loaded targets are forced onto the instruction granule
   always_comb begin
      w_target            = '0;
      w_target_misaligned = 1'b0;
      w_next_pc           = r_pc;
      case (w_sel)
         SEL_TRAP:  w_target = bus.trap_vector;
         SEL_REDIR: w_target = bus.redirect_target;
         SEL_RAS:   w_target = w_ras_top;
         default:   w_target = '0;
      endcase
      case (w_sel)
         SEL_SEQ:  w_next_pc = r_pc + XLEN'(INST_BYTES);
         SEL_HOLD: w_next_pc = r_pc;
         default: begin
            w_next_pc           = w_target & ALIGN_MASK;
            w_target_misaligned = |(w_target & ~ALIGN_MASK);
         end
      endcase
   end

   // PC register and one-cycle status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc         <= RESET_VECTOR;
         r_pc_valid   <= 1'b0;
         r_flush      <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_pc         <= w_next_pc;
         r_pc_valid   <= 1'b1;
         r_flush      <= (w_sel == SEL_TRAP) || (w_sel == SEL_REDIR);
         r_misaligned <= w_target_misaligned;
      end
   end

   return_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.ras_push),
      .push_addr (bus.ras_push_addr),
      .pop       (w_ras_pop),
      .clear     (bus.trap_valid),
      .top       (w_ras_top),
      .empty     (w_ras_empty)
   );

   // Output drive
   always_comb begin
      bus.pc_out     = r_pc;
      bus.pc_valid   = r_pc_valid;
      bus.pc_plus    = r_pc + XLEN'(INST_BYTES);
      bus.flush      = r_flush;
      bus.misaligned = r_misaligned;
      bus.ras_empty  = w_ras_empty;
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pc_sequencer_if #(.XLEN(64)) bus ();

   pc_sequencer #(
      .XLEN         (64),
      .RESET_VECTOR (64'h1000),
      .INST_BYTES   (4),
      .RAS_DEPTH    (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.stall           = 1'b0;
      bus.fetch_ready     = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.trap_valid      = 1'b0;
      bus.trap_vector     = '0;
      bus.ras_push        = 1'b0;
      bus.ras_push_addr   = '0;
      bus.ras_pop         = 1'b0;
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_pc",        bus.pc_out,     64'h1000);
      chk("rst_valid",     bus.pc_valid,   64'h0);
      chk("rst_flush",     bus.flush,      64'h0);
      chk("rst_mis",       bus.misaligned, 64'h0);
      chk("rst_ras_empty", bus.ras_empty,  64'h1);
      chk("rst_pc_plus",   bus.pc_plus,    64'h1004);

      // Release: valid rises at edge 1, then sequential fetch
      reset = 1'b1;
      tick();
      chk("e1_pc",    bus.pc_out,   64'h1000);
      chk("e1_valid", bus.pc_valid, 64'h1);
      tick();
      chk("e2_pc", bus.pc_out, 64'h1004);
      tick();
      chk("e3_pc", bus.pc_out, 64'h1008);

      // Stall holds the PC
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", bus.pc_out, 64'h1008);
      end

      // Redirect overrides stall
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h2000;
      tick();
      chk("redir_pc",    bus.pc_out, 64'h2000);
      chk("redir_flush", bus.flush,  64'h1);
      bus.redirect_valid = 1'b0;
      tick();
      chk("redir_flush_end", bus.flush,  64'h0);
      chk("redir_hold",      bus.pc_out, 64'h2000);
      bus.stall = 1'b0;

      // One push, then trap + redirect + push together
      bus.ras_push      = 1'b1;
      bus.ras_push_addr = 64'h3000;
      tick();
      chk("push1_pc",    bus.pc_out,    64'h2004);
      chk("push1_empty", bus.ras_empty, 64'h0);
      bus.ras_push_addr   = 64'h4000;
      bus.trap_valid      = 1'b1;
      bus.trap_vector     = 64'h80;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h2000;
      tick();
      chk("trap_pc",    bus.pc_out,    64'h80);
      chk("trap_flush", bus.flush,     64'h1);
      chk("trap_empty", bus.ras_empty, 64'h1);
      bus.ras_push       = 1'b0;
      bus.trap_valid     = 1'b0;
      bus.redirect_valid = 1'b0;
      tick();
      chk("post_trap_pc",    bus.pc_out, 64'h84);
      chk("post_trap_flush", bus.flush,  64'h0);

      // Five pushes into depth-4 RAS while stalled
      bus.stall    = 1'b1;
      bus.ras_push = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         bus.ras_push_addr = 64'(i) * 64'h100;
         tick();
      end
      bus.ras_push = 1'b0;
      chk("push5_pc",    bus.pc_out,    64'h84);
      chk("push5_empty", bus.ras_empty, 64'h0);

      // Pops return E, D, C, B then fall back to sequential
      bus.stall   = 1'b0;
      bus.ras_pop = 1'b1;
      tick();
      chk("pop_e", bus.pc_out, 64'h500);
      chk("pop_e_flush", bus.flush, 64'h0);
      tick();
      chk("pop_d", bus.pc_out, 64'h400);
      tick();
      chk("pop_c", bus.pc_out, 64'h300);
      tick();
      chk("pop_b", bus.pc_out, 64'h200);
      chk("pop_b_empty", bus.ras_empty, 64'h1);
      tick();
      chk("pop_empty_seq", bus.pc_out,    64'h204);
      chk("pop_empty_flg", bus.ras_empty, 64'h1);
      bus.ras_pop = 1'b0;

      // Misaligned redirect
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'h2002;
      tick();
      chk("mis_pc",   bus.pc_out,     64'h2000);
      chk("mis_flag", bus.misaligned, 64'h1);
      bus.redirect_valid = 1'b0;
      tick();
      chk("mis_end_pc",   bus.pc_out,     64'h2004);
      chk("mis_end_flag", bus.misaligned, 64'h0);

      // Simultaneous push + pop
      bus.ras_push      = 1'b1;
      bus.ras_push_addr = 64'h600;
      tick();
      chk("pp_seq", bus.pc_out, 64'h2008);
      bus.ras_push_addr = 64'h700;
      bus.ras_pop       = 1'b1;
      tick();
      chk("pp_pc",    bus.pc_out,    64'h600);
      chk("pp_empty", bus.ras_empty, 64'h0);
      bus.ras_push = 1'b0;
      tick();
      chk("pp_new_top", bus.pc_out,    64'h700);
      chk("pp_drained", bus.ras_empty, 64'h1);
      bus.ras_pop = 1'b0;

      // Asynchronous reset mid-cycle
      bus.ras_push      = 1'b1;
      bus.ras_push_addr = 64'h900;
      tick();
      bus.ras_push = 1'b0;
      chk("pre_rst_empty", bus.ras_empty, 64'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_pc",    bus.pc_out,    64'h1000);
      chk("async_rst_valid", bus.pc_valid,  64'h0);
      chk("async_rst_empty", bus.ras_empty, 64'h1);
      tick();
      chk("rst_held_pc", bus.pc_out, 64'h1000);

      // Wrap-around at the top of the address space
      reset               = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      chk("wrap_load", bus.pc_out,  64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_plus", bus.pc_plus, 64'h0);
      bus.redirect_valid = 1'b0;
      tick();
      chk("wrap_pc", bus.pc_out, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
